// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Opcode constants, decoded-slot record and opcode-class helpers
//               shared by the dual-issue scheduler and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // One buffered instruction slot as delivered by decode
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] instr;
    } slot_t;

    function automatic logic is_legal(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LOAD);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE);
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic is_load(input logic [6:0] op);
        return op == OP_LOAD;
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register 2-bit busy countdown for x1..x31. Two set ports
//               (one per issue lane) and six busy lookups. x0 is never busy.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      set_en,
    input  logic [1:0][4:0] set_rd,
    input  logic [1:0][1:0] set_val,
    input  logic [5:0][4:0] look_reg,
    output logic [5:0]      busy
);

    logic [31:0] busy_vec;

    assign busy_vec[0] = 1'b0;

    generate
        for (genvar r = 1; r < 32; r++) begin : g_reg
            logic [1:0] cnt;

            // Load on issue of a writer, otherwise count down to zero
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= 2'd0;
                end else if (set_en[0] && (set_rd[0] == 5'(r))) begin
                    cnt <= set_val[0];
                end else if (set_en[1] && (set_rd[1] == 5'(r))) begin
                    cnt <= set_val[1];
                end else if (cnt != 2'd0) begin
                    cnt <= cnt - 2'd1;
                end
            end

            assign busy_vec[r] = (cnt != 2'd0);
        end

        for (genvar i = 0; i < 6; i++) begin : g_look
            assign busy[i] = busy_vec[look_reg[i]];
        end
    endgenerate

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dual_issue_scheduler
// Description : In-order two-wide issue controller. Buffers one decoded pair,
//               issues 0/1/2 instructions per cycle under scoreboard, intra-
//               pair dependency and single-memory-port constraints.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_issue_scheduler
    import riscv_pkg::*;
#(
    parameter int ALU_LAT  = 1,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             en_flag_i,
    input  logic [31:0]      c_i,
    input  logic [6:0]       opcode_1,
    input  logic [4:0]       rs1_1,
    input  logic [4:0]       rs2_1,
    input  logic [4:0]       rd_1,
    input  logic [31:0]      instr_1_,
    input  logic [6:0]       opcode_2,
    input  logic [4:0]       rs1_2,
    input  logic [4:0]       rs2_2,
    input  logic [4:0]       rd_2,
    input  logic [31:0]      instr_2_,
    input  logic             issue_ready_i,
    output logic             ready_o,
    output logic             iss0_valid_o,
    output logic [31:0]      iss0_instr_o,
    output logic             iss1_valid_o,
    output logic [31:0]      iss1_instr_o,
    output logic [31:0]      iss_c_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    // Counter load values: a latency of L means the consumer waits L-1 cycles
    localparam logic [1:0] ALU_SET  = 2'(ALU_LAT - 1);
    localparam logic [1:0] LOAD_SET = 2'(LOAD_LAT - 1);

    slot_t       s0, s1;
    logic        v0, v1;
    logic [31:0] tag;

    logic [5:0]      busy;
    logic [5:0][4:0] look_reg;
    logic [1:0]      set_en;
    logic [1:0][4:0] set_rd;
    logic [1:0][1:0] set_val;

    logic s0_ok, s1_ok, raw, waw, mem2, pair_conflict;
    logic iss0, iss1, accept, go;
    logic bad1, bad2;

    assign ready_o = !v0 && !v1;
    assign accept  = en_flag_i && ready_o && !flush_i;
    assign go      = issue_ready_i && !flush_i;
    assign bad1    = (opcode_1 != 7'd0) && !is_legal(opcode_1);
    assign bad2    = (opcode_2 != 7'd0) && !is_legal(opcode_2);

    assign look_reg[0] = s0.rs1;
    assign look_reg[1] = s0.rs2;
    assign look_reg[2] = s0.rd;
    assign look_reg[3] = s1.rs1;
    assign look_reg[4] = s1.rs2;
    assign look_reg[5] = s1.rd;

    // Per-slot readiness against the scoreboard, then intra-pair hazards
    always_comb begin
        s0_ok = v0 && !busy[0]
                && (!reads_rs2(s0.opcode) || !busy[1])
                && (!writes_rd(s0.opcode) || !busy[2]);
        s1_ok = v1 && !busy[3]
                && (!reads_rs2(s1.opcode) || !busy[4])
                && (!writes_rd(s1.opcode) || !busy[5]);
        raw   = writes_rd(s0.opcode) && (s0.rd != 5'd0)
                && ((s0.rd == s1.rs1) || (reads_rs2(s1.opcode) && (s0.rd == s1.rs2)));
        waw   = writes_rd(s0.opcode) && writes_rd(s1.opcode)
                && (s0.rd != 5'd0) && (s0.rd == s1.rd);
        mem2  = is_mem(s0.opcode) && is_mem(s1.opcode);
        pair_conflict = raw || waw || mem2;
        iss0  = go && s0_ok;
        iss1  = go && s1_ok && (v0 ? (s0_ok && !pair_conflict) : 1'b1);
    end

    assign set_en[0]  = iss0 && writes_rd(s0.opcode);
    assign set_rd[0]  = s0.rd;
    assign set_val[0] = is_load(s0.opcode) ? LOAD_SET : ALU_SET;
    assign set_en[1]  = iss1 && writes_rd(s1.opcode);
    assign set_rd[1]  = s1.rd;
    assign set_val[1] = is_load(s1.opcode) ? LOAD_SET : ALU_SET;

    regfile_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (set_en),
        .set_rd   (set_rd),
        .set_val  (set_val),
        .look_reg (look_reg),
        .busy     (busy)
    );

    // Pair buffer: flush beats accept beats per-slot issue clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0  <= 1'b0;
            v1  <= 1'b0;
            s0  <= '0;
            s1  <= '0;
            tag <= 32'd0;
        end else if (flush_i) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end else if (accept) begin
            v0  <= (opcode_1 != 7'd0) && !bad1;
            v1  <= (opcode_2 != 7'd0) && !bad2;
            s0  <= '{opcode_1, rs1_1, rs2_1, rd_1, instr_1_};
            s1  <= '{opcode_2, rs1_2, rs2_2, rd_2, instr_2_};
            tag <= c_i;
        end else begin
            if (iss0) v0 <= 1'b0;
            if (iss1) v1 <= 1'b0;
        end
    end

    // Registered issue lanes; the oldest issued instruction always takes lane 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss0_valid_o <= 1'b0;
            iss1_valid_o <= 1'b0;
            iss0_instr_o <= 32'd0;
            iss1_instr_o <= 32'd0;
            iss_c_o      <= 32'd0;
        end else begin
            iss0_valid_o <= iss0 || iss1;
            iss1_valid_o <= iss0 && iss1;
            if (iss0 || iss1) begin
                iss0_instr_o <= iss0 ? s0.instr : s1.instr;
                iss1_instr_o <= (iss0 && iss1) ? s1.instr : 32'd0;
                iss_c_o      <= tag;
            end
        end
    end

    // Illegal-opcode pulse and hazard-stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_o   <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            illegal_o <= accept && (bad1 || bad2);
            if (go && (v0 || v1) && !iss0 && !iss1)
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule : dual_issue_scheduler
`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_issue_scheduler
// Description : Directed self-checking bench for dual_issue_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_issue_scheduler;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] XX = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i, en_flag_i, issue_ready_i;
    logic [31:0] c_i;
    logic [6:0]  opcode_1, opcode_2;
    logic [4:0]  rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2;
    logic [31:0] instr_1_, instr_2_;
    logic        ready_o, iss0_valid_o, iss1_valid_o, illegal_o;
    logic [31:0] iss0_instr_o, iss1_instr_o, iss_c_o, stall_cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dual_issue_scheduler #(.ALU_LAT(1), .LOAD_LAT(2), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .en_flag_i(en_flag_i),
        .c_i(c_i),
        .opcode_1(opcode_1), .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1), .instr_1_(instr_1_),
        .opcode_2(opcode_2), .rs1_2(rs1_2), .rs2_2(rs2_2), .rd_2(rd_2), .instr_2_(instr_2_),
        .issue_ready_i(issue_ready_i), .ready_o(ready_o),
        .iss0_valid_o(iss0_valid_o), .iss0_instr_o(iss0_instr_o),
        .iss1_valid_o(iss1_valid_o), .iss1_instr_o(iss1_instr_o),
        .iss_c_o(iss_c_o), .illegal_o(illegal_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tg, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a pair for one edge, then drop en_flag_i
    task automatic accept_pair(input logic [6:0] o1, input logic [4:0] a1, b1, d1,
                               input logic [31:0] w1,
                               input logic [6:0] o2, input logic [4:0] a2, b2, d2,
                               input logic [31:0] w2, input logic [31:0] tg);
        opcode_1 = o1; rs1_1 = a1; rs2_1 = b1; rd_1 = d1; instr_1_ = w1;
        opcode_2 = o2; rs1_2 = a2; rs2_2 = b2; rd_2 = d2; instr_2_ = w2;
        c_i = tg;
        en_flag_i = 1'b1;
        step();
        en_flag_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush_i = 1'b0; en_flag_i = 1'b0; issue_ready_i = 1'b1;
        c_i = '0; opcode_1 = '0; opcode_2 = '0;
        rs1_1 = '0; rs2_1 = '0; rd_1 = '0; rs1_2 = '0; rs2_2 = '0; rd_2 = '0;
        instr_1_ = '0; instr_2_ = '0;
        repeat (2) step();

        // Reset state
        chk("rst_iss0_valid", 32'(iss0_valid_o), 32'd0);
        chk("rst_iss1_valid", 32'(iss1_valid_o), 32'd0);
        chk("rst_stall",      stall_cnt_o,       32'd0);
        chk("rst_illegal",    32'(illegal_o),    32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", 32'(ready_o), 32'd1);

        // 1: independent ADD x1,x2,x3 + ADDI x4,x5,7 -> dual issue
        accept_pair(R, 5'd2, 5'd3, 5'd1, 32'h003100B3,
                    I, 5'd5, 5'd7, 5'd4, 32'h00728213, 32'd10);
        chk("t1_busy_ready", 32'(ready_o), 32'd0);
        chk("t1_no_early",   32'(iss0_valid_o), 32'd0);
        step();
        chk("t1_v0",    32'(iss0_valid_o), 32'd1);
        chk("t1_i0",    iss0_instr_o,      32'h003100B3);
        chk("t1_v1",    32'(iss1_valid_o), 32'd1);
        chk("t1_i1",    iss1_instr_o,      32'h00728213);
        chk("t1_tag",   iss_c_o,           32'd10);
        chk("t1_ready", 32'(ready_o),      32'd1);
        chk("t1_stall", stall_cnt_o,       32'd0);
        step();
        chk("t1_pulse", 32'(iss0_valid_o), 32'd0);

        // 2: ADD x1,x2,x3 + SUB x6,x1,x2 -> RAW splits the pair
        accept_pair(R, 5'd2, 5'd3, 5'd1, 32'h003100B3,
                    R, 5'd1, 5'd2, 5'd6, 32'h40208333, 32'd20);
        step();
        chk("t2_v0N",   32'(iss0_valid_o), 32'd1);
        chk("t2_i0N",   iss0_instr_o,      32'h003100B3);
        chk("t2_v1N",   32'(iss1_valid_o), 32'd0);
        chk("t2_rdyN",  32'(ready_o),      32'd0);
        step();
        chk("t2_v0N1",  32'(iss0_valid_o), 32'd1);
        chk("t2_i0N1",  iss0_instr_o,      32'h40208333);
        chk("t2_v1N1",  32'(iss1_valid_o), 32'd0);
        chk("t2_rdy",   32'(ready_o),      32'd1);
        chk("t2_stall", stall_cnt_o,       32'd0);

        // 3: LW x3,0(x1) + ADD x7,x3,x3 -> one load-use stall
        accept_pair(LD, 5'd1, 5'd0, 5'd3, 32'h0000A183,
                    R,  5'd3, 5'd3, 5'd7, 32'h003183B3, 32'd30);
        step();
        chk("t3_lw",     iss0_instr_o,      32'h0000A183);
        chk("t3_lw_v1",  32'(iss1_valid_o), 32'd0);
        step();
        chk("t3_hole",   32'(iss0_valid_o), 32'd0);
        chk("t3_stall1", stall_cnt_o,       32'd1);
        step();
        chk("t3_add_v",  32'(iss0_valid_o), 32'd1);
        chk("t3_add",    iss0_instr_o,      32'h003183B3);
        chk("t3_stall",  stall_cnt_o,       32'd1);

        // 4: LW x3,0(x1) + SW x5,4(x2) -> serialized on the memory port
        accept_pair(LD, 5'd1, 5'd0, 5'd3, 32'h0000A183,
                    ST, 5'd2, 5'd5, 5'd4, 32'h00512223, 32'd40);
        step();
        chk("t4_lw",    iss0_instr_o,      32'h0000A183);
        chk("t4_lw_v1", 32'(iss1_valid_o), 32'd0);
        step();
        chk("t4_sw_v",  32'(iss0_valid_o), 32'd1);
        chk("t4_sw",    iss0_instr_o,      32'h00512223);
        chk("t4_stall", stall_cnt_o,       32'd1);

        // 5: ADDI x0,x0,1 + ADD x1,x0,x0 -> x0 never creates a hazard
        accept_pair(I, 5'd0, 5'd1, 5'd0, 32'h00100013,
                    R, 5'd0, 5'd0, 5'd1, 32'h000000B3, 32'd50);
        step();
        chk("t5_v0", 32'(iss0_valid_o), 32'd1);
        chk("t5_v1", 32'(iss1_valid_o), 32'd1);
        chk("t5_i1", iss1_instr_o,      32'h000000B3);

        // Illegal slot 0, legal slot 1 -> slot 1 alone goes to lane 0
        accept_pair(XX, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF,
                    R,  5'd3, 5'd4, 5'd2, 32'h00418133, 32'd60);
        chk("t5_ill",     32'(illegal_o),    32'd1);
        chk("t5_ill_rdy", 32'(ready_o),      32'd0);
        step();
        chk("t5_ill_end", 32'(illegal_o),    32'd0);
        chk("t5_l0_v",    32'(iss0_valid_o), 32'd1);
        chk("t5_l0",      iss0_instr_o,      32'h00418133);
        chk("t5_l1_v",    32'(iss1_valid_o), 32'd0);
        chk("t5_l0_tag",  iss_c_o,           32'd60);

        // Both slots illegal -> one pulse, nothing buffered
        accept_pair(XX, 5'd0, 5'd0, 5'd0, 32'h1, XX, 5'd0, 5'd0, 5'd0, 32'h2, 32'd61);
        chk("t5_ill2",     32'(illegal_o), 32'd1);
        chk("t5_ill2_rdy", 32'(ready_o),   32'd1);
        step();
        chk("t5_ill2_end", 32'(illegal_o),    32'd0);
        chk("t5_ill2_iss", 32'(iss0_valid_o), 32'd0);

        // 6: hold with issue_ready_i=0, then flush
        issue_ready_i = 1'b0;
        accept_pair(R, 5'd9, 5'd10, 5'd8, 32'h00A48433,
                    I, 5'd12, 5'd1, 5'd11, 32'h00160593, 32'd70);
        repeat (3) step();
        chk("t6_hold_v",     32'(iss0_valid_o), 32'd0);
        chk("t6_hold_stall", stall_cnt_o,       32'd1);
        chk("t6_hold_rdy",   32'(ready_o),      32'd0);
        flush_i = 1'b1;
        issue_ready_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("t6_flush_rdy", 32'(ready_o),      32'd1);
        chk("t6_flush_iss", 32'(iss0_valid_o), 32'd0);
        chk("t6_flush_stl", stall_cnt_o,       32'd1);

        // Reset in the middle of a load-use stall
        accept_pair(LD, 5'd1, 5'd0, 5'd13, 32'h0000A683,
                    R,  5'd13, 5'd13, 5'd14, 32'h00D68733, 32'd80);
        step();
        chk("t6_lw", iss0_instr_o, 32'h0000A683);
        step();
        chk("t6_stall2", stall_cnt_o, 32'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_v0",    32'(iss0_valid_o), 32'd0);
        chk("t6_rst_i0",    iss0_instr_o,      32'd0);
        chk("t6_rst_tag",   iss_c_o,           32'd0);
        chk("t6_rst_stall", stall_cnt_o,       32'd0);
        chk("t6_rst_rdy",   32'(ready_o),      32'd1);
        #3;
        rst_n = 1'b1;
        step();
        step();
        chk("t6_post_iss", 32'(iss0_valid_o), 32'd0);
        chk("t6_post_stl", stall_cnt_o,       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_dual_issue_scheduler
`default_nettype wire
